inst_rom_loader: RTL
====================

Name: inst_rom_loader

Overview:
- Instruction-memory responder for the core's fetch port: accepts the core's chip-enable and byte address, returns the 32-bit instruction word.
- Holds a word-addressed instruction array written by a streaming loader port (valid/ready), so a program can be loaded at run time.
- Drives a hold signal that keeps the core stalled or reset while the array is not yet valid.
- Sits beside the CPU top at SoC level; fetch side is combinational to match the core's single-cycle fetch.

Parameters:
- DEPTH, 1024, number of 32-bit instruction words.
- AW, 10, word-index width; must satisfy 2**AW == DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rom_ce_i  input  1  fetch enable from core.
- rom_addr_i  input  32  fetch byte address from core.
- rom_data_o  output  32  instruction word.
- fetch_err_o  output  1  registered one-cycle pulse on bad fetch.
- ld_start_i  input  1  begin (re)load at word 0.
- ld_valid_i  input  1  loader word valid.
- ld_data_i  input  32  loader word.
- ld_last_i  input  1  marks final loader word.
- ld_ready_o  output  1  loader may transfer.
- ld_count_o  output  AW+1  words written by current/last load.
- ld_err_o  output  1  sticky overflow flag for current load.
- rom_ready_o  output  1  array valid, fetches served.
- cpu_hold_o  output  1  keep core stalled.
- parity_err_o  output  1  see Optional Feature.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, ld_count_o=0, ld_err_o=0, rom_ready_o=0, cpu_hold_o=1, fetch_err_o=0, parity_err_o=0. Array contents are not cleared.
- FSM states:
  - IDLE: ld_ready_o=0; ld_start_i moves to LOAD, clears ld_count_o and ld_err_o.
  - LOAD: ld_ready_o=1. On each valid&ready beat, write ld_data_i to index ld_count_o and increment the count.
    - Beat with ld_last_i: goes to RUN.
    - Beat that fills index DEPTH-1 without last: sets ld_err_o, goes to DRAIN.
  - DRAIN: ld_ready_o=1; beats are accepted and dropped, count frozen at DEPTH; last beat goes to RUN.
  - RUN: rom_ready_o=1, cpu_hold_o=0, ld_ready_o=0; ld_start_i returns to LOAD (same clears; rom_ready_o=0 and cpu_hold_o=1 from the next cycle).
- ld_start_i while in LOAD or DRAIN is ignored.
- In IDLE, ld_start_i together with ld_valid_i: the start takes effect and no beat transfers that cycle.
- A last beat that is also index DEPTH-1 is written, goes to RUN, and does not set ld_err_o.
- Fetch path (combinational):
  - rom_data_o = array[rom_addr_i[AW+1:2]] when rom_ce_i=1 and state=RUN; otherwise 0.
  - Bad fetch = rom_ce_i=1 and (rom_addr_i[1:0]!=0 or rom_addr_i[31:AW+2]!=0 or state!=RUN). rom_data_o=0 on a bad fetch.
  - fetch_err_o pulses high the cycle after each bad fetch.
- Reset mid-load: returns to IDLE; partially written words remain but rom_ready_o=0 until a full new load completes.
- The array has one write port (loader) and one asynchronous read port (fetch); no read/write collision exists because fetch is served only in RUN.

Optional Feature:
- Macro INST_ROM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed on write.
  - A RUN-state good fetch whose recomputed parity mismatches gives a one-cycle registered pulse on parity_err_o the next cycle.
  - rom_data_o still returns the stored word.
- Undefined: no parity storage; parity_err_o tied 0.

Decomposition:
- Shared package/define file: InstBus width 32, ROM DEPTH/AW defaults, FSM state encoding (IDLE, LOAD, DRAIN, RUN).
- Sub-module inst_rom_mem: storage array, write port, async read port, optional parity bit and check.
- FSM, counter and flag logic live in inst_rom_loader.

Test Plan:
- Reset, pulse ld_start_i, stream 0x34011100, 0x34020020, 0x3403FF00, 0x3404FFFF (last on 4th) -> ld_count_o=4, rom_ready_o=1, cpu_hold_o=0. Then fetch addr 0x8 -> rom_data_o=0x3403FF00; addr 0x10 -> word 4 contents, no fetch_err_o.
- Fetch addr 0x0 with ce=1 during LOAD -> rom_data_o=0, fetch_err_o pulse next cycle; ce=0 in RUN -> rom_data_o=0, no pulse.
- RUN, fetch addr 0x6 (misaligned) and 0x1000 (DEPTH=1024, out of range) -> rom_data_o=0, fetch_err_o pulse each.
- DEPTH=4 build: stream 6 words, last on 6th -> words 0..3 written, ld_err_o=1, ld_count_o=4, state RUN after 6th beat; ld_valid_i held with ready toggling confirms one write per handshake.
- Assert rst low mid-load after 2 beats -> all outputs at reset values immediately, cpu_hold_o=1; new load of 1 word with last -> rom_ready_o=1, ld_count_o=1.
- INST_ROM_PARITY_EN: force-flip one stored bit of word 1, fetch addr 0x4 -> parity_err_o pulse next cycle; clean word -> no pulse.

Source files
------------

// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader: bus width, default
// geometry and the loader FSM state encoding.
package inst_rom_loader_pkg;

    localparam int INST_W    = 32;
    localparam int ROM_DEPTH = 1024;
    localparam int ROM_AW    = 10;

    typedef logic [INST_W-1:0] inst_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RUN   = 2'd3
    } ld_state_e;

endpackage

// File: rtl/inst_rom_mem.sv
// Instruction storage: one synchronous write port for the loader and one
// asynchronous read port for the fetch path.
// With INST_ROM_PARITY_EN defined, each word carries an even-parity bit
// computed on write, and par_mismatch flags a word whose parity no longer
// checks on read.
module inst_rom_mem
    import inst_rom_loader_pkg::*;
#(
    parameter int DEPTH = ROM_DEPTH,
    parameter int AW    = ROM_AW
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [INST_W-1:0] rdata,
    output logic              par_mismatch
);

`ifdef INST_ROM_PARITY_EN
    logic [INST_W:0] mem [DEPTH];

    // Loader write: store the word with its even-parity bit on top.
    // NOTE: the array has no reset; contents survive rst and only the loader writes them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= {^wdata, wdata};
        end
    end

    assign rdata        = mem[raddr][INST_W-1:0];
    assign par_mismatch = ^mem[raddr];
`else
    logic [INST_W-1:0] mem [DEPTH];

    // Loader write: plain 32-bit word.
    // NOTE: the array has no reset; contents survive rst and only the loader writes them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata        = mem[raddr];
    assign par_mismatch = 1'b0;
`endif

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction-memory responder for the core fetch port with a streaming
// valid/ready loader. The core is held until a full load completes; fetches
// are served combinationally only in RUN. Optional word parity checking is
// enabled with INST_ROM_PARITY_EN (see inst_rom_mem); when it is undefined
// parity_err_o stays 0.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int DEPTH = ROM_DEPTH,
    parameter int AW    = ROM_AW      // 2**AW must equal DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [INST_W-1:0] rom_addr_i,
    output logic [INST_W-1:0] rom_data_o,
    output logic              fetch_err_o,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [INST_W-1:0] ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic [AW:0]       ld_count_o,
    output logic              ld_err_o,
    output logic              rom_ready_o,
    output logic              cpu_hold_o,
    output logic              parity_err_o
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    ld_state_e         state_q, state_d;
    logic [AW:0]       count_q, count_d;
    logic              err_q, err_d;
    logic              fetch_err_q, parity_err_q;
    logic              mem_we;
    logic              in_run, addr_ok, good_fetch, bad_fetch;
    logic [INST_W-1:0] rd_data;
    logic              par_mismatch;

    inst_rom_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk          (clk),
        .we           (mem_we),
        .waddr        (count_q[AW-1:0]),
        .wdata        (ld_data_i),
        .raddr        (rom_addr_i[AW+1:2]),
        .rdata        (rd_data),
        .par_mismatch (par_mismatch)
    );

    // Fetch qualification: aligned, inside the array, and only while running.
    assign in_run     = (state_q == ST_RUN);
    assign addr_ok    = (rom_addr_i[1:0] == 2'b00) && ((rom_addr_i >> (AW + 2)) == '0);
    assign good_fetch = rom_ce_i && addr_ok && in_run;
    assign bad_fetch  = rom_ce_i && !good_fetch;
    assign rom_data_o = good_fetch ? rd_data : '0;

    // Next-state, loader handshake and write-enable decode.
    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        err_d      = err_q;
        ld_ready_o = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (ld_start_i) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                ld_ready_o = 1'b1;
                if (ld_valid_i) begin
                    mem_we  = 1'b1;
                    count_d = count_q + (AW+1)'(1);
                    if (ld_last_i) begin
                        state_d = ST_RUN;
                    end else if (count_q == LAST_IDX) begin
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                ld_ready_o = 1'b1;
                if (ld_valid_i && ld_last_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter, sticky overflow and the one-cycle error pulses.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            err_q        <= 1'b0;
            fetch_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            err_q        <= err_d;
            fetch_err_q  <= bad_fetch;
            parity_err_q <= good_fetch && par_mismatch;
        end
    end

    assign ld_count_o   = count_q;
    assign ld_err_o     = err_q;
    assign rom_ready_o  = in_run;
    assign cpu_hold_o   = !in_run;
    assign fetch_err_o  = fetch_err_q;
    assign parity_err_o = parity_err_q;

endmodule
